// File: rtl/wb_cmd_master.sv
// Converts one command into one Wishbone classic cycle and holds the result as a response.
// Latency: accept edge N, ack at edge N+k -> cyc/stb high cycles N+1..N+k, rsp_valid from N+k+1.
// Backpressure: cmd_ready only in IDLE; the response is held until rsp_ready, then one IDLE cycle.
module wb_cmd_master #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [3:0]  cmd_sel,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Last wait-counter value before the cycle is abandoned.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] rsp_dat_q, rsp_dat_d;
  logic        rsp_err_q, rsp_err_d;
  logic [15:0] cnt_q, cnt_d;

  // Next-state and datapath decode; everything holds unless the state says otherwise.
  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    we_d      = we_q;
    sel_d     = sel_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    rsp_dat_d = rsp_dat_q;
    rsp_err_d = rsp_err_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          we_d    = cmd_we;
          sel_d   = cmd_sel;
          adr_d   = cmd_adr;
          dat_d   = cmd_dat;
          cyc_d   = 1'b1;
          cnt_d   = 16'd0;
          state_d = BUS;
        end
      end
      BUS: begin
        if (wbm_ack_i) begin
          // Ack takes priority over a timeout landing on the same edge.
          cyc_d     = 1'b0;
          rsp_err_d = 1'b0;
          rsp_dat_d = we_q ? 32'h0 : wbm_dat_i;
          state_d   = RESP;
        end else if (cnt_q == CNT_LAST) begin
          cyc_d     = 1'b0;
          rsp_err_d = 1'b1;
          rsp_dat_d = 32'h0;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RESP: begin
        // Acks seen here are stray and are dropped.
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
      end
    endcase
  end

  // State and datapath registers, cleared immediately on reset.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      sel_q     <= 4'h0;
      adr_q     <= 32'h0;
      dat_q     <= 32'h0;
      rsp_dat_q <= 32'h0;
      rsp_err_q <= 1'b0;
      cnt_q     <= 16'd0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_err_q <= rsp_err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_dat   = rsp_dat_q;
  assign rsp_err   = rsp_err_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;

endmodule

// File: doc/wb_cmd_master.md
WB_CMD_MASTER -- requirements
Module: wb_cmd_master

Interface
REQ-001 The block SHALL expose parameter TIMEOUT, default 64, the maximum number of cycles a bus cycle waits for ack before it is aborted (legal range 2..65535).
REQ-002 The block SHALL have port wb_clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port wb_rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port cmd_valid, input, 1 bit: a command is offered.
REQ-005 The block SHALL have port cmd_ready, output, 1 bit: a command is accepted when cmd_valid and cmd_ready are both high at a rising edge.
REQ-006 The block SHALL have ports cmd_we (input, 1 bit, 1 = write), cmd_sel (input, 4 bits, byte lanes), cmd_adr (input, 32 bits, address) and cmd_dat (input, 32 bits, write data).
REQ-007 The block SHALL have port rsp_valid, output, 1 bit: a response is held.
REQ-008 The block SHALL have port rsp_ready, input, 1 bit: the response is consumed when rsp_valid and rsp_ready are both high at a rising edge.
REQ-009 The block SHALL have ports rsp_dat (output, 32 bits, read data) and rsp_err (output, 1 bit, 1 = timeout).
REQ-010 The block SHALL have Wishbone master outputs wbm_cyc_o (1 bit), wbm_stb_o (1 bit), wbm_we_o (1 bit), wbm_sel_o (4 bits), wbm_adr_o (32 bits) and wbm_dat_o (32 bits).
REQ-011 The block SHALL have Wishbone master inputs wbm_ack_i (1 bit) and wbm_dat_i (32 bits).

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, BUS and RESP.
REQ-013 cmd_ready SHALL be high exactly when the state is IDLE; it is decoded combinationally from the state register.
REQ-014 IDLE with cmd_valid high: at the edge, the block SHALL register cmd_we/sel/adr/dat onto the wbm_* outputs, set wbm_cyc_o = wbm_stb_o = 1, clear the wait counter to 0 and go to BUS.
REQ-015 In BUS, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o and wbm_dat_o SHALL stay stable until the cycle ends.
REQ-016 All wbm_* outputs SHALL be driven from flops, with no combinational path from any input.
REQ-017 BUS with wbm_ack_i high at an edge: the block SHALL clear wbm_cyc_o and wbm_stb_o at that same edge, set rsp_err = 0, and go to RESP.
REQ-018 On that ack edge, rsp_dat SHALL capture wbm_dat_i for a read and SHALL be set to 32'h0 for a write.
REQ-019 BUS with wbm_ack_i low: the wait counter (16 bits) SHALL increment by 1 at each edge.
REQ-020 When the wait counter equals TIMEOUT-1 and wbm_ack_i is low, the block SHALL clear wbm_cyc_o and wbm_stb_o, set rsp_err = 1 and rsp_dat = 32'h0, and go to RESP.
REQ-021 If ack and timeout fall on the same edge, the ack SHALL win: rsp_err = 0 and the data is captured.
REQ-022 The counter SHALL never wrap: a cycle spans at most TIMEOUT edges in BUS.
REQ-023 In RESP, rsp_valid SHALL be 1, and rsp_dat and rsp_err SHALL hold their values until the handshake.
REQ-024 When rsp_ready is high in RESP, the block SHALL go to IDLE at that edge; rsp_valid is 0 in every other state.
REQ-025 wbm_ack_i SHALL be ignored in IDLE and RESP: no state or data change.
REQ-026 A new command SHALL not be accepted in the same edge as a response handshake; there is at least one IDLE cycle between transactions.
REQ-027 Latency SHALL be as follows: with accept edge N and ack sampled at edge N+k (k >= 1), cyc/stb are high for cycles N+1..N+k and rsp_valid is high from cycle N+k+1; zero-wait ack gives k = 1.
REQ-028 wbm_we_o, wbm_sel_o, wbm_adr_o and wbm_dat_o SHALL keep their last values after the cycle ends; only cyc/stb fall.

Reset
REQ-029 Asserting wb_rst_i SHALL immediately, without waiting for a clock edge, force: state IDLE, wbm_cyc_o = wbm_stb_o = 0, wbm_we_o = 0, wbm_sel_o = 0, wbm_adr_o = 0, wbm_dat_o = 0, rsp_valid = 0, rsp_dat = 0, rsp_err = 0, counter = 0.
REQ-030 Reset during BUS or RESP SHALL abort the transaction with no response produced; cmd_ready is high from the first edge after reset deasserts.

Verification
REQ-031 Write: cmd adr = 0x3000_0004, dat = 0xDEAD_BEEF, sel = 0xF, we = 1; slave acks on its 3rd stb cycle -> cyc/stb high for exactly 3 cycles with stable adr/dat, then rsp_valid = 1, rsp_err = 0, rsp_dat = 0.
REQ-032 Read with zero wait: slave acks in the first stb cycle with wbm_dat_i = 0x1234_5678 -> cyc/stb high for 1 cycle, rsp_dat = 0x1234_5678, rsp_err = 0.
REQ-033 Timeout with TIMEOUT = 4 and no ack -> cyc/stb high for exactly 4 cycles, then rsp_err = 1, rsp_dat = 0.
REQ-034 Same-edge race: ack arrives exactly on the TIMEOUT-th cycle -> rsp_err = 0 and the data is captured.
REQ-035 Backpressure: rsp_ready held low for 10 cycles -> rsp_valid and rsp_dat stay stable and cmd_ready stays 0; spurious wbm_ack_i pulses in that window change nothing.
REQ-036 Reset mid-BUS: wb_rst_i asserted while cyc = 1 -> cyc/stb drop with no clock edge, rsp_valid never rises, and the next command completes normally.
